// File: rtl/joy_port.sv
// joy_port: NES-style $4016/$4017 serial controller port fed by 12-bit Sega pad words.
// Define JOY_TURBO_EN to add X/Y turbo autofire on NES A/B.
module joy_port #(
   parameter int TURBO_DIV = 416666
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  din,
   input  logic        we,
   input  logic        rd,
   input  logic [11:0] joy1,
   input  logic [11:0] joy2,
   output logic [7:0]  dout,
   output logic        strobe
);

   // Sega word (active-low) to NES byte {R,L,D,U,Start,Select,B,A}
   function automatic logic [7:0] pack(
      input logic [11:0] j,
      input logic        tp
   );
      logic [11:0] p;
      logic        ud;
      logic        lr;
      logic        a;
      logic        b;
      p  = ~j;
      ud = p[4] & p[5];
      lr = p[6] & p[7];
      a  = p[1] | (p[11] & tp);
      b  = p[0] | (p[10] & tp);
      return {p[7] & ~lr, p[6] & ~lr,
              p[5] & ~ud, p[4] & ~ud,
              p[3], p[2] | p[8], b, a};
   endfunction

   logic phase;

`ifdef JOY_TURBO_EN
   localparam int CW = $clog2(TURBO_DIV + 1);
   logic [CW-1:0] tcnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tcnt  <= '0;
         phase <= 1'b0;
      end else if (tcnt == CW'(TURBO_DIV - 1)) begin
         tcnt  <= '0;
         phase <= ~phase;
      end else begin
         tcnt  <= tcnt + CW'(1);
      end
   end
`else
   assign phase = 1'b0;
`endif

   logic       hit1;
   logic       hit2;
   logic [7:0] p1;
   logic [7:0] p2;
   logic [7:0] sr1;
   logic [7:0] sr2;

   assign hit1 = (address == 16'h4016);
   assign hit2 = (address == 16'h4017);
   assign p1   = pack(joy1, phase);
   assign p2   = pack(joy2, phase);

   // A write in the same cycle as a read suppresses the shift
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         strobe <= 1'b0;
         sr1    <= 8'hFF;
         sr2    <= 8'hFF;
      end else begin
         if (we && hit1)
            strobe <= din[0];
         if (strobe) begin
            sr1 <= p1;
            sr2 <= p2;
         end else if (rd && !we) begin
            if (hit1)
               sr1 <= {1'b1, sr1[7:1]};
            if (hit2)
               sr2 <= {1'b1, sr2[7:1]};
         end
      end
   end

   always_comb begin
      dout = 8'h00;
      if (hit1)
         dout = {3'b010, 4'b0000, sr1[0]};
      else if (hit2)
         dout = {3'b010, 4'b0000, sr2[0]};
   end

endmodule

// File: doc/joy_port.md
Name: joy_port

Overview:
- CPU-facing controller port for the Dendy core; consumes the 12-bit pad words produced by the Sega-pad scanner, one per pad.
- Presents them to the 6502 bus as NES-standard serial controller registers: $4016 write = strobe, $4016 read = pad 1, $4017 read = pad 2.
- Handles latch-on-strobe, serial shifting, post-8-bit fill and the A/B/Select/Start mapping from Sega button layout.

Parameters:
- TURBO_DIV, 416666, clocks per turbo half-period (25 MHz / 416666 ≈ 30 Hz toggle); used only with JOY_TURBO_EN.

Ports:
- clock    input   1   system clock, 25 MHz
- reset    input   1   asynchronous, active-high reset
- address  input   16  CPU address bus
- din      input   8   CPU write data
- we       input   1   one-cycle write pulse; valid with address/din
- rd       input   1   one-cycle read pulse; marks the clock edge that completes a CPU read
- joy1     input   12  pad 1, active-low; bits 11..0 = X Y Z C R L D U Mode Start A B
- joy2     input   12  pad 2, same format
- dout     output  8   read data for $4016/$4017
- strobe   output  1   current strobe latch (debug/visibility)

Behaviour:
- Button mapping: pressed = ~joy bit.
  - NES A = A(1), B = B(0), Select = Mode(2) | C(8), Start = Start(3), Up = U(4), Down = D(5), Left = L(6), Right = R(7).
  - Packed NES byte P[7:0] = {Right, Left, Down, Up, Start, Select, B, A}; bit 0 shifts out first.
- Opposing-direction filter: Up & Down both pressed → both reported released; same for Left & Right.
- Strobe: a we to $4016 sets strobe <= din[0]. A we to any other address is ignored.
- While strobe = 1, both shift registers sr1/sr2 reload from P1/P2 every clock. A rd does not shift, so reads return the live A state.
- Strobe 1→0: registers hold the value loaded on the last cycle with strobe = 1.
- Shifting:
  - rd at $4016 with strobe = 0 → sr1 <= {1'b1, sr1[7:1]}.
  - rd at $4017 with strobe = 0 → sr2 <= {1'b1, sr2[7:1]}.
  - After 8 shifts, every further read returns 1 indefinitely; no wrap-around.
- dout: combinational.
  - address = $4016 → {3'b010, 4'b0000, sr1[0]}.
  - address = $4017 → {3'b010, 4'b0000, sr2[0]}.
  - Any other address → 8'h00.
  - Value in the rd cycle is the pre-shift bit; the shifted value is visible the next cycle.
- Simultaneous we and rd in one cycle: the write is applied and no shift occurs that cycle.
- A rd on one port never disturbs the other pad's register.
- joy1/joy2 are sampled only through the reload path; changes while strobe = 0 are invisible until the next strobe.
- Reset (asynchronous, any time, including mid-sequence): strobe = 0, sr1 = sr2 = 8'hFF, turbo counter and phase = 0. dout then reads $41 at $4016/$4017.

Optional Feature:
- Macro: JOY_TURBO_EN.
- Defined:
  - A free-running counter toggles a turbo phase every TURBO_DIV clocks.
  - X (bit 11) pressed ORs (phase & 1) into NES A; Y (bit 10) pressed ORs (phase & 1) into NES B, per pad.
  - Counter and phase reset to 0.
- Undefined: X, Y and Z are ignored; no counter logic is synthesised.

Test Plan:
- Reset: assert reset mid-shift → strobe = 0; read $4016 → $41; read $4017 → $41.
- Pad 1 A + Start + Right pressed (joy1 = 12'hF75): write $4016 = 1, then 0; 8 reads $4016 → bit0 sequence 1,0,0,1,0,0,0,1; 9th and 10th reads → 1.
- Strobe held: write $4016 = 1, joy1 A pressed; 3 reads → 1,1,1. Release A (joy1 = 12'hFFF) → next read → 0. No shifting occurs.
- Independence and filter: joy2 Up + Down pressed, joy1 idle; latch, then 8 reads of $4017 → all 0. $4016 read afterwards → bit0 = 0, sr1 unshifted.
- Select via C: joy1 bit 8 = 0; latch; reads 1–3 of $4016 → 0,0,1. Issue we $4016 = 0 and rd in the same cycle → dout bit0 = pre-shift value, no shift that cycle.
- JOY_TURBO_EN with TURBO_DIV = 4: X held; latch each clock with strobe = 1 and read $4016 → A toggles every 4 clocks. Without the macro → A constant 0.
